// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and constants for the program-counter sequencer
package pc_seq_pkg;

    localparam int PC_ADDR_W = 6;

    typedef enum logic [2:0] {
        OP_NEXT   = 3'd0,
        OP_JUMP   = 3'd1,
        OP_BRANCH = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4,
        OP_HALT   = 3'd5
    } flow_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_HALTED = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// rtl/pc_sequencer_ret_stack.sv - LIFO return-address stack with combinational top read
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic                     clk,
    input  logic                     nReset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             top,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]   r_mem [DEPTH];
    logic [PTR_W:0] r_level;
    logic [PTR_W:0] w_lvl_m1;

    assign w_lvl_m1 = r_level - (PTR_W+1)'(1);
    assign top      = r_mem[w_lvl_m1[PTR_W-1:0]];
    assign full     = (r_level == (PTR_W+1)'(DEPTH));
    assign empty    = (r_level == '0);
    assign level    = r_level;

    always_ff @(posedge clk) begin
        if (nReset) begin
            r_level <= '0;
        end else if (push && !full) begin
            r_level <= r_level + (PTR_W+1)'(1);
        end else if (pop && !empty) begin
            r_level <= w_lvl_m1;
        end
    end

    // Storage needs no reset: entries above the level are never read.
    always_ff @(posedge clk) begin
        if (!nReset && push && !full) begin
            r_mem[r_level[PTR_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/decode FSM owning the program address and return stack
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                 ADDR_W       = PC_ADDR_W,
    parameter int                 STACK_DEPTH  = 4,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0
) (
    input  logic                           clk,
    input  logic                           nReset,
    input  logic                           run,
    output logic                           imem_req,
    output logic [ADDR_W-1:0]              imem_addr,
    input  logic                           imem_ack,
    input  logic                           op_valid,
    input  logic [2:0]                     op,
    input  logic [ADDR_W-1:0]              target,
    input  logic                           cond,
    output logic                           halted,
    output logic                           stack_err,
    output logic [$clog2(STACK_DEPTH):0]   stack_lvl
);
    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_top;
    logic              r_err;
    logic              w_err_set;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;

    assign w_pc_inc  = r_pc + ADDR_W'(1);
    assign imem_req  = (r_state == ST_FETCH);
    assign imem_addr = r_pc;
    assign halted    = (r_state == ST_HALTED);
    assign stack_err = r_err;

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_ret_stack (
        .clk    (clk),
        .nReset (nReset),
        .push   (w_push),
        .pop    (w_pop),
        .din    (w_pc_inc),
        .top    (w_top),
        .full   (w_full),
        .empty  (w_empty),
        .level  (stack_lvl)
    );

    always_ff @(posedge clk) begin
        if (nReset) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_VECTOR;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_err   <= r_err | w_err_set;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) w_state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (op_valid) begin
                    w_state_nxt = run ? ST_FETCH : ST_IDLE;
                    // Reserved encodings fall through to default and behave as NEXT.
                    case (flow_op_t'(op))
                        OP_JUMP:   w_pc_nxt = target;
                        OP_BRANCH: w_pc_nxt = cond ? target : w_pc_inc;
                        OP_CALL: begin
                            if (w_full) begin
                                w_err_set   = 1'b1;
                                w_state_nxt = ST_HALTED;
                            end else begin
                                w_push   = 1'b1;
                                w_pc_nxt = target;
                            end
                        end
                        OP_RET: begin
                            if (w_empty) begin
                                w_err_set   = 1'b1;
                                w_state_nxt = ST_HALTED;
                            end else begin
                                w_pop    = 1'b1;
                                w_pc_nxt = w_top;
                            end
                        end
                        OP_HALT:   w_state_nxt = ST_HALTED;
                        default:   w_pc_nxt = w_pc_inc;
                    endcase
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer with directed flow-op vectors
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic       clk = 1'b0;
    logic       nReset;
    logic       run;
    logic       imem_req;
    logic [5:0] imem_addr;
    logic       imem_ack;
    logic       op_valid;
    logic [2:0] op;
    logic [5:0] target;
    logic       cond;
    logic       halted;
    logic       stack_err;
    logic [2:0] stack_lvl;

    int checks   = 0;
    int failures = 0;
    logic [5:0] exp_q[$];

    pc_sequencer #(.ADDR_W(6), .STACK_DEPTH(4), .RESET_VECTOR(6'd0)) dut (
        .clk       (clk),
        .nReset    (nReset),
        .run       (run),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .op_valid  (op_valid),
        .op        (op),
        .target    (target),
        .cond      (cond),
        .halted    (halted),
        .stack_err (stack_err),
        .stack_lvl (stack_lvl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every acknowledged fetch must match the next scoreboard address.
    initial begin
        forever begin
            @(negedge clk);
            if (!nReset && imem_req && imem_ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL fetch_addr actual=%0d expected=none", imem_addr);
                end else begin
                    logic [5:0] e;
                    e = exp_q.pop_front();
                    if (imem_addr !== e) begin
                        failures++;
                        $display("FAIL fetch_addr actual=%0d expected=%0d", imem_addr, e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        nReset = 1'b1;
        repeat (cycles) step();
        nReset = 1'b0;
    endtask

    // One instruction: wait for the fetch, stall, ack, then present the flow op.
    task automatic instr(input logic [5:0] exp_addr, input int stall, input logic [2:0] o,
                         input logic [5:0] tgt, input logic c, input logic run_after);
        int n;
        exp_q.push_back(exp_addr);
        imem_ack = 1'b0;
        n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        if (!imem_req) begin
            chk("fetch_timeout", 32'(imem_req), 32'd1);
            return;
        end
        for (int i = 0; i < stall; i++) begin
            step();
            chk("stall_req", 32'(imem_req), 32'd1);
            chk("stall_addr", 32'(imem_addr), 32'(exp_addr));
        end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        chk("decode_req_low", 32'(imem_req), 32'd0);
        op_valid = 1'b1;
        op       = o;
        target   = tgt;
        cond     = c;
        run      = run_after;
        step();
        op_valid = 1'b0;
    endtask

    initial begin
        nReset = 1'b1; run = 1'b0; imem_ack = 1'b0; op_valid = 1'b0;
        op = 3'd0; target = 6'd0; cond = 1'b0;
        do_reset(2);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_err", 32'(stack_err), 32'd0);
        chk("rst_lvl", 32'(stack_lvl), 32'd0);
        chk("rst_no_x", 32'($isunknown({imem_req, imem_addr, halted, stack_err, stack_lvl})), 32'd0);

        run = 1'b1;
        instr(6'd0, 0, OP_NEXT, 6'd0, 1'b0, 1'b1);
        instr(6'd1, 0, OP_NEXT, 6'd0, 1'b0, 1'b1);
        instr(6'd2, 0, 3'd6,    6'd0, 1'b0, 1'b1);
        instr(6'd3, 0, OP_JUMP, 6'd4, 1'b0, 1'b1);
        instr(6'd4, 0, OP_BRANCH, 6'd20, 1'b0, 1'b1);
        instr(6'd5, 0, OP_BRANCH, 6'd20, 1'b1, 1'b1);
        instr(6'd20, 0, OP_JUMP, 6'd9, 1'b0, 1'b1);
        instr(6'd9, 0, OP_JUMP, 6'd63, 1'b0, 1'b1);
        instr(6'd63, 5, OP_NEXT, 6'd0, 1'b0, 1'b1);
        instr(6'd0, 0, OP_JUMP, 6'd10, 1'b0, 1'b1);

        instr(6'd10, 0, OP_CALL, 6'd30, 1'b0, 1'b1);
        chk("call1_lvl", 32'(stack_lvl), 32'd1);
        instr(6'd30, 0, OP_CALL, 6'd40, 1'b0, 1'b1);
        chk("call2_lvl", 32'(stack_lvl), 32'd2);
        instr(6'd40, 0, OP_RET, 6'd0, 1'b0, 1'b1);
        instr(6'd31, 0, OP_RET, 6'd0, 1'b0, 1'b1);
        chk("ret_lvl", 32'(stack_lvl), 32'd0);

        instr(6'd11, 0, OP_NEXT, 6'd0, 1'b0, 1'b0);
        chk("idle_req", 32'(imem_req), 32'd0);
        chk("idle_addr", 32'(imem_addr), 32'd12);
        step();
        chk("idle_hold", 32'(imem_req), 32'd0);
        run = 1'b1;
        step();
        chk("resume_req", 32'(imem_req), 32'd1);
        chk("resume_addr", 32'(imem_addr), 32'd12);
        nReset = 1'b1;
        step();
        nReset = 1'b0;
        chk("midrst_req", 32'(imem_req), 32'd0);
        chk("midrst_addr", 32'(imem_addr), 32'd0);

        instr(6'd0, 0, OP_CALL, 6'd1, 1'b0, 1'b1);
        instr(6'd1, 0, OP_CALL, 6'd2, 1'b0, 1'b1);
        instr(6'd2, 0, OP_CALL, 6'd3, 1'b0, 1'b1);
        instr(6'd3, 0, OP_CALL, 6'd4, 1'b0, 1'b1);
        chk("full_lvl", 32'(stack_lvl), 32'd4);
        instr(6'd4, 0, OP_CALL, 6'd50, 1'b0, 1'b1);
        chk("ovf_halted", 32'(halted), 32'd1);
        chk("ovf_err", 32'(stack_err), 32'd1);
        chk("ovf_addr", 32'(imem_addr), 32'd4);
        chk("ovf_lvl", 32'(stack_lvl), 32'd4);
        imem_ack = 1'b1; op_valid = 1'b1; op = OP_JUMP; target = 6'd33;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_addr", 32'(imem_addr), 32'd4);
        end
        imem_ack = 1'b0; op_valid = 1'b0;

        do_reset(2);
        chk("rst2_err", 32'(stack_err), 32'd0);
        chk("rst2_halted", 32'(halted), 32'd0);
        chk("rst2_lvl", 32'(stack_lvl), 32'd0);
        instr(6'd0, 0, OP_RET, 6'd0, 1'b0, 1'b1);
        chk("unf_halted", 32'(halted), 32'd1);
        chk("unf_err", 32'(stack_err), 32'd1);
        chk("unf_addr", 32'(imem_addr), 32'd0);
        step();
        chk("unf_req", 32'(imem_req), 32'd0);

        do_reset(1);
        instr(6'd0, 0, OP_JUMP, 6'd7, 1'b0, 1'b1);
        instr(6'd7, 0, OP_HALT, 6'd0, 1'b0, 1'b1);
        chk("halt_op_halted", 32'(halted), 32'd1);
        chk("halt_op_err", 32'(stack_err), 32'd0);
        chk("halt_op_addr", 32'(imem_addr), 32'd7);

        step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller that owns the 6-bit program address and sequences instruction fetch for the core.
- Issues one fetch request per instruction to instruction memory and waits for the acknowledge.
- After the fetch, applies the decoder's flow op (next, jump, branch, call, return, halt) to pick the next address.
- Supersedes the free-running counter: adds stall, flow control and a small hardware return stack.

Parameters:
- ADDR_W, 6, width of program address.
- STACK_DEPTH, 4, return-stack entries (power of two, >=2).
- RESET_VECTOR, 0, address loaded on reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- nReset  input  1  reset, synchronous, active-high (nReset=1 resets).
- run  input  1  enable; sampled in IDLE and at op acceptance.
- imem_req  output  1  fetch request; high only in state FETCH.
- imem_addr  output  ADDR_W  fetch address; equals pc register.
- imem_ack  input  1  memory acknowledge; meaningful only while imem_req=1.
- op_valid  input  1  decoder presents a flow op.
- op  input  3  0 NEXT, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5 HALT, 6-7 reserved (treated as NEXT).
- target  input  ADDR_W  destination for JUMP/BRANCH/CALL.
- cond  input  1  branch condition for BRANCH.
- halted  output  1  high in state HALTED.
- stack_err  output  1  sticky; set on overflow/underflow.
- stack_lvl  output  $clog2(STACK_DEPTH)+1  current stack occupancy.

Behaviour:
- Reset (nReset=1 at posedge): state=IDLE, pc=RESET_VECTOR, stack_lvl=0, imem_req=0, halted=0, stack_err=0. Reset wins over every other input, in any state, including mid-fetch.
- State IDLE:
  - run=1 -> FETCH next cycle.
  - run=0 -> stay.
- State FETCH:
  - imem_req=1, imem_addr=pc.
  - Hold until imem_ack=1 (an unbounded stall is legal).
  - imem_ack at cycle N -> DECODE at N+1, with imem_req=0 at N+1.
- State DECODE:
  - Wait for op_valid. op_valid at cycle M -> new pc at M+1.
  - From M+1 the state is FETCH if run=1, else IDLE (pc already updated).
  - Minimum 2 cycles per instruction with zero-wait memory.
- Next-pc rules (all arithmetic mod 2^ADDR_W; 63+1 -> 0):
  - NEXT/reserved: pc+1.
  - JUMP: target.
  - BRANCH: target if cond=1, else pc+1.
  - CALL: push pc+1, then pc=target.
  - RET: pop the top entry into pc.
  - HALT: pc unchanged; state HALTED.
- Stack:
  - LIFO, STACK_DEPTH entries.
  - CALL with stack_lvl=STACK_DEPTH: no push, pc unchanged, stack_err=1, state HALTED.
  - RET with stack_lvl=0: pc unchanged, stack_err=1, state HALTED.
- HALTED: imem_req=0, halted=1; ignores run, op_valid and imem_ack. Exits only via reset.
- Inputs outside their state: imem_ack outside FETCH and op_valid outside DECODE are ignored and have no side effects.
- run=0 while in FETCH: does not abort the outstanding fetch; run is checked at op acceptance.

Decomposition:
- Shared package pc_seq_pkg:
  - enum flow_op_t (NEXT..HALT, 3 bits).
  - enum seq_state_t (IDLE, FETCH, DECODE, HALTED).
  - ADDR_W default constant.
- One natural sub-module, ret_stack:
  - Parameterised LIFO with push/pop/full/empty/level.
  - Write on push, combinational top-of-stack read, no simultaneous push+pop.
- FSM and next-pc mux stay in pc_sequencer.

Test Plan:
- Reset/linear: nReset=1 two cycles, then run=1, ack every FETCH, op=NEXT each DECODE -> imem_addr sequence 0,1,2,3; imem_req high on alternate cycles; no outputs X after reset.
- Wrap and stall: pc at 63, ack delayed 5 cycles -> imem_req held 6 cycles at addr 63; after NEXT, next fetch addr=0.
- Branch/jump: at pc=4, BRANCH target=20 cond=0 -> 5; at pc=5, BRANCH target=20 cond=1 -> 20; JUMP target=9 -> 9.
- Call/return: nested CALL 10->30, then CALL 30->40 -> stack_lvl=2; RET -> 31; RET -> 11; stack_lvl=0.
- Stack errors:
  - 4 nested CALLs then a 5th -> HALTED, stack_err=1, pc unchanged, imem_req stays 0 even with run=1.
  - Separately, RET from empty -> same result.
- Reset mid-operation and run drop:
  - nReset=1 while in FETCH at addr 12 -> next cycle IDLE, pc=0, imem_req=0.
  - run=0 at op acceptance -> IDLE with updated pc; run=1 resumes fetch at that pc.
